// File: rtl/register_file_2r1w.sv
// Parametrised 2-read / 1-write flip-flop register file with a hardware clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards a same-edge array write to the read ports.
module register_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic [ADDR_W-1:0] rAddr0,
    output logic [DATA_W-1:0] rData0,
    input  logic [ADDR_W-1:0] rAddr1,
    output logic [DATA_W-1:0] rData1,
    input  logic              clr,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              busy_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] rd0_next_s;
    logic [DATA_W-1:0] rd1_next_s;

    // Select the single array write source: sweep, accepted user write, or none (clr wins over we).
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (we && !clr) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = wAddr;
                    wr_data_s = wData;
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_ptr_r;
                wr_data_s = '0;
            end
            default: begin
                wr_en_s   = 1'b0;
            end
        endcase
    end

    // Next read data; with forwarding, a same-edge array write overrides the stored value.
    always_comb begin
        rd0_next_s = mem_r[rAddr0];
        rd1_next_s = mem_r[rAddr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_s && (wr_addr_s == rAddr0)) begin
            rd0_next_s = wr_data_s;
        end else begin
            rd0_next_s = mem_r[rAddr0];
        end
        if (wr_en_s && (wr_addr_s == rAddr1)) begin
            rd1_next_s = wr_data_s;
        end else begin
            rd1_next_s = mem_r[rAddr1];
        end
`else
        rd0_next_s = mem_r[rAddr0];
        rd1_next_s = mem_r[rAddr1];
`endif
    end

    // Clear sequencer: clr in IDLE starts a sweep of every entry; clr during a sweep is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            clr_ptr_r <= '0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= '0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_ptr_r == LAST_PTR) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clr_ptr_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered read ports, updated every edge including during a sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            rdata0_r <= rd0_next_s;
            rdata1_r <= rd1_next_s;
        end
    end

    assign rData0 = rdata0_r;
    assign rData1 = rdata1_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: directed vector table, clear-sweep
// sequences, mid-sweep reset and randomized traffic against a behavioural model.
module tb_register_file_2r1w;

    localparam int DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [2:0]  rAddr0;
    logic [31:0] rData0;
    logic [2:0]  rAddr1;
    logic [31:0] rData1;
    logic        clr;
    logic        busy;

    register_file_2r1w #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
        .rAddr0(rAddr0), .rData0(rData0), .rAddr1(rAddr1), .rData1(rData1),
        .clr(clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array plus count of sweep writes still to come.
    logic [31:0] ref_mem [DEPTH];
    int          sweep_left = 0;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic        clr;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        expbusy;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        sweep_left = 0;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs #1 after the edge.
    task automatic step(input logic i_we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic [2:0] a0, input logic [2:0] a1, input logic i_clr);
        bit          hit;
        int          w_a;
        logic [31:0] w_d;
        logic [31:0] e0;
        logic [31:0] e1;
        we = i_we; wAddr = wa; wData = wd; rAddr0 = a0; rAddr1 = a1; clr = i_clr;
        @(posedge clk);
        hit = 1'b0; w_a = 0; w_d = 32'h0;
        if (sweep_left > 0) begin
            hit = 1'b1; w_a = DEPTH - sweep_left; w_d = 32'h0;
            sweep_left--;
        end else if (i_clr) begin
            sweep_left = DEPTH;
        end else if (i_we) begin
            hit = 1'b1; w_a = int'(wa); w_d = wd;
        end
        e0 = (BYP && hit && (w_a == int'(a0))) ? w_d : ref_mem[a0];
        e1 = (BYP && hit && (w_a == int'(a1))) ? w_d : ref_mem[a1];
        if (hit) ref_mem[w_a] = w_d;
        #1;
        check("model_rdata0", rData0, e0);
        check("model_rdata1", rData1, e1);
        check("model_busy", {31'h0, busy}, {31'h0, (sweep_left > 0)});
    endtask

    task automatic idle(input logic [2:0] a0, input logic [2:0] a1);
        step(1'b0, 3'd0, 32'h0, a0, a1, 1'b0);
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; we = 1'b0; wAddr = 3'd0; wData = 32'h0;
        rAddr0 = 3'd0; rAddr1 = 3'd0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata0", rData0, 32'h0);
        check("reset_rdata1", rData1, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors: write/read latency, dual-port same address, same-edge forwarding.
        vecs[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 3'd2, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 3'd0, 32'h0, 3'd2, 3'd5, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 3'd3, 32'hAAAA0000, 3'd3, 3'd3, 1'b0,
                    BYP ? 32'hAAAA0000 : 32'h0, BYP ? 32'hAAAA0000 : 32'h0, 1'b0};
        vecs[4] = '{1'b1, 3'd3, 32'h12345678, 3'd3, 3'd5, 1'b0,
                    BYP ? 32'h12345678 : 32'hAAAA0000, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 3'd0, 32'h0, 3'd3, 3'd3, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1, vecs[i].clr);
            check($sformatf("vec%0d_rdata0", i), rData0, vecs[i].exp0);
            check($sformatf("vec%0d_rdata1", i), rData1, vecs[i].exp1);
            check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].expbusy});
        end

        // Fill, sweep with a dropped write to addr 0, busy lasts exactly DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 32'h100 + 32'(i), 3'd0, 3'd1, 1'b0);
        step(1'b0, 3'd0, 32'h0, 3'd0, 3'd7, 1'b1);
        cnt = busy ? 1 : 0;
        for (int k = 0; k < 20 && busy; k++) begin
            step(1'b1, 3'd0, 32'h00000BAD, 3'd0, 3'd7, 1'b0);
            if (busy) cnt++;
        end
        check("sweep_busy_cycles", 32'(cnt), 32'd8);
        idle(3'd0, 3'd0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(3'(i), 3'(DEPTH - 1 - i));
            check($sformatf("cleared_addr%0d", i), rData0, 32'h0);
        end

        // clr and we on the same idle edge: clr wins.
        step(1'b1, 3'd7, 32'h55, 3'd7, 3'd7, 1'b1);
        for (int k = 0; k < 20 && busy; k++) idle(3'd7, 3'd7);
        check("clr_we_busy_done", {31'h0, busy}, 32'h0);
        idle(3'd7, 3'd7);
        check("clr_we_addr7", rData0, 32'h0);

        // Second clr mid-sweep does not restart the sweep.
        step(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b1);
        cnt = busy ? 1 : 0;
        repeat (3) begin idle(3'd0, 3'd0); if (busy) cnt++; end
        step(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b1);
        if (busy) cnt++;
        for (int k = 0; k < 20 && busy; k++) begin
            idle(3'd0, 3'd0);
            if (busy) cnt++;
        end
        check("double_clr_busy_cycles", 32'(cnt), 32'd8);

        // Reset mid-sweep after four entries cleared.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 32'hC0DE0000 + 32'(i), 3'd0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 32'h0, 3'd6, 3'd7, 1'b1);
        repeat (4) idle(3'd6, 3'd7);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_rdata0", rData0, 32'h0);
        check("midreset_rdata1", rData1, 32'h0);
        check("midreset_busy", {31'h0, busy}, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            idle(3'(i), 3'(i));
            check($sformatf("post_reset_addr%0d", i), rData1, 32'h0);
        end
        step(1'b1, 3'd6, 32'h77, 3'd0, 3'd0, 1'b0);
        idle(3'd6, 3'd6);
        check("post_reset_write", rData0, 32'h77);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
